// File: rtl/logic_gate_pipe.sv
// -----------------------------------------------------------------------------
// logic_gate_pipe
//   Registered, WIDTH-bit bitwise gate unit with valid/ready handshakes on both
//   sides. Each accepted beat either produces one result directly (single-beat
//   operation) or contributes to a multi-beat accumulate packet. A packet folds
//   every beat's A operand into a running value using the gate latched on the
//   packet's first beat, and emits one result when its last beat arrives.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//   CNT_W      width of the saturating beat counter (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   beat is accepted when in_valid && in_ready
//   in_a       operand A
//   in_b       operand B (first beat of a packet only)
//   in_op      gate select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR,
//              6 NOT A, 7 BUF A
//   in_acc     1 = this beat starts a multi-beat accumulate packet
//   in_last    final beat of an accumulate packet
//   out_valid  result valid
//   out_ready  consumer accepts when out_valid && out_ready
//   out_y      result
//   out_beats  number of beats folded into out_y (saturating)
// -----------------------------------------------------------------------------
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_BUFA = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bitwise gate shared by the first beat (A op B) and the fold (acc op A).
  function automatic logic [WIDTH-1:0] gate(input op_e op,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    // NOTE: a default is assigned before the case so every path drives the
    // result; combinational code with an unassigned path infers a latch.
    gate = x;
    unique case (op)
      OP_AND:  gate = x & y;
      OP_OR:   gate = x | y;
      OP_NAND: gate = ~(x & y);
      OP_NOR:  gate = ~(x | y);
      OP_XOR:  gate = x ^ y;
      OP_XNOR: gate = ~(x ^ y);
      OP_NOTA: gate = ~x;
      OP_BUFA: gate = x;
    endcase
  endfunction

  // Packet state
  state_e           state,   state_next;
  logic [WIDTH-1:0] acc,     acc_next;
  logic [CNT_W-1:0] cnt,     cnt_next;
  op_e              op_q,    op_next;

  // Result load request towards the output register
  logic             load;
  logic [WIDTH-1:0] y_load;
  logic [CNT_W-1:0] beats_load;

  logic             xfer;
  logic [WIDTH-1:0] first_f;
  logic [WIDTH-1:0] fold_f;
  logic [CNT_W-1:0] cnt_sat;

  // The output register frees up either when empty or when the consumer takes
  // the current result this cycle; this also gates non-last packet beats so the
  // stall rule does not depend on where a beat sits within a packet.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  assign first_f  = gate(op_e'(in_op), in_a, in_b);
  assign fold_f   = gate(op_q, acc, in_a);
  // Counter sticks at all-ones instead of wrapping back to a small value.
  assign cnt_sat  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // ---------------------------------------------------------------------------
  // Next-state and result-load logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    op_next    = op_q;
    load       = 1'b0;
    y_load     = '0;
    beats_load = '0;

    if (xfer) begin
      unique case (state)
        ST_IDLE: begin
          if (in_acc && !in_last) begin
            acc_next   = first_f;
            op_next    = op_e'(in_op);
            cnt_next   = CNT_ONE;
            state_next = ST_ACCUM;
          end else begin
            // Plain beat, or a packet that is both first and last.
            load       = 1'b1;
            y_load     = first_f;
            beats_load = CNT_ONE;
          end
        end
        ST_ACCUM: begin
          // Inside a packet in_op, in_acc and in_b are don't-cares.
          acc_next = fold_f;
          cnt_next = cnt_sat;
          if (in_last) begin
            load       = 1'b1;
            y_load     = fold_f;
            beats_load = cnt_sat;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Packet state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_q  <= OP_AND;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values, independent of statement order.
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: holds the result until the consumer takes it. A new
  // result loading in the same cycle as a take keeps out_valid high, giving
  // one result per cycle when out_ready stays asserted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_beats <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_y     <= y_load;
      out_beats <= beats_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_gate_pipe
//   Scoreboard bench for logic_gate_pipe. Accepted beats feed a packet-level
//   reference model that pushes expected results into a queue; an independent
//   monitor pops and compares whenever the DUT hands over a result. Directed
//   scenarios (op sweep, back-pressure, NAND chain, resets, saturation) are
//   followed by a randomized phase with random back-pressure.
// -----------------------------------------------------------------------------
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_acc, in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [7:0] out_beats;

  // Second instance with a 4-bit counter for the saturation scenario
  logic       s_in_valid, s_in_ready;
  logic [7:0] s_in_a, s_in_b;
  logic [2:0] s_in_op;
  logic       s_in_acc, s_in_last;
  logic       s_out_valid, s_out_ready;
  logic [7:0] s_out_y;
  logic [3:0] s_out_beats;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_beats(out_beats)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op),
    .in_acc(s_in_acc), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_y(s_out_y), .out_beats(s_out_beats)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-bit truth tables, packet folding, saturating count
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] y;
    logic [7:0] beats;
  } exp_t;

  exp_t sb[$];
  bit         in_pkt = 0;
  logic [7:0] m_acc;
  logic [2:0] m_op;
  int         m_n;

  // Truth table bit index is {x,y}; e.g. AND is 1 only for x=1,y=1 (index 3).
  function automatic logic [7:0] gate_ref(input logic [2:0] op,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0111;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0110;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  function automatic void model_accept(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input bit acc,
                                       input bit last);
    logic [7:0] r;
    if (!in_pkt) begin
      r = gate_ref(op, a, b);
      if (acc && !last) begin
        in_pkt = 1;
        m_acc  = r;
        m_op   = op;
        m_n    = 1;
      end else begin
        sb.push_back('{y: r, beats: 8'd1});
      end
    end else begin
      m_acc = gate_ref(m_op, m_acc, a);
      m_n   = (m_n < 255) ? m_n + 1 : 255;
      if (last) begin
        sb.push_back('{y: m_acc, beats: 8'(m_n)});
        in_pkt = 0;
      end
    end
  endfunction

  bit stalled = 0;
  logic [7:0] held_y, held_b;

  function automatic void model_reset();
    in_pkt  = 0;
    stalled = 0;
    sb.delete();
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: called between edges; returns at posedge+1 after the beat is taken
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input bit acc, input bit last);
    bit ok = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
    end else begin
      model_accept(a, b, op, acc, last);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: handshake rule, output hold, scoreboard comparison
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (stalled && out_valid) begin
          check("hold_y", out_y, held_y);
          check("hold_beats", out_beats, held_b);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got y=0x%0h beats=%0d, expected no result",
                     out_y, out_beats);
          end else begin
            e = sb.pop_front();
            check("sb_y", out_y, e.y);
            check("sb_beats", out_beats, e.beats);
          end
        end
        stalled = out_valid && !out_ready;
        held_y  = out_y;
        held_b  = out_beats;
      end
    end
  end

  // Random back-pressure, enabled only in the randomized phase
  bit rand_ready = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] sweep_exp [8];
    time t0;
    int len;
    logic [2:0] op;
    bit acc;

    sweep_exp = '{8'h88, 8'hEE, 8'h77, 8'h11, 8'h66, 8'h99, 8'h33, 8'hCC};

    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_acc = 0; in_last = 0;
    out_ready = 1'b1;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_op = 0; s_in_acc = 0;
    s_in_last = 0; s_out_ready = 1'b1;

    // Reset state
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_y", out_y, 0);
    check("reset_out_beats", out_beats, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: op sweep, one result per cycle, latency 1
    for (int i = 0; i < 8; i++) begin
      t0 = $time;
      send(8'hCC, 8'hAA, 3'(i), 1'b0, 1'b0);
      check("sweep_accept_cycles", 32'($time - t0), 10);
      check("sweep_valid", out_valid, 1);
      check("sweep_y", out_y, sweep_exp[i]);
      check("sweep_beats", out_beats, 1);
    end

    // 2: back-pressure
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'hF0, 8'hCC, 3'd2, 1'b0, 1'b0);
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_y", out_y, 8'h3F);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_drained", out_valid, 0);

    // 3: NAND chain with junk op/acc/b on later beats
    send(8'hFF, 8'h0F, 3'd2, 1'b1, 1'b0);
    send(8'hFF, 8'($urandom), 3'd5, 1'b0, 1'b0);
    check("chain_no_early_out", out_valid, 0);
    send(8'h3C, 8'($urandom), 3'd0, 1'b1, 1'b1);
    check("chain_valid", out_valid, 1);
    check("chain_y", out_y, 8'hF3);
    check("chain_beats", out_beats, 3);
    @(posedge clk);
    #1;

    // 4: reset in the middle of a packet
    send(8'h12, 8'h34, 3'd1, 1'b1, 1'b0);
    send(8'h55, 8'h00, 3'd1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_pkt_valid", out_valid, 0);
    check("rst_pkt_y", out_y, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h0F, 8'h3C, 3'd0, 1'b0, 1'b0);
    check("post_rst_y", out_y, 8'h0C);
    check("post_rst_beats", out_beats, 1);
    @(posedge clk);
    #1;

    // 5: counter saturation on the CNT_W=4 instance
    s_in_valid = 1'b1; s_in_op = 3'd4; s_in_a = 8'h01; s_in_b = 8'h00;
    s_in_acc = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      s_in_last = (k == 20);
      if (k == 1 || k == 20) check("sat_in_ready", s_in_ready, 1);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    check("sat_valid", s_out_valid, 1);
    check("sat_y", s_out_y, 8'h00);
    check("sat_beats", s_out_beats, 15);

    // 6: asynchronous reset between clock edges
    out_ready = 1'b0;
    send(8'hA5, 8'h0F, 3'd4, 1'b0, 1'b0);
    check("async_pre_valid", out_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_y", out_y, 0);
    check("async_beats", out_beats, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Randomized packets with random back-pressure
    rand_ready = 1;
    repeat (250) begin
      op  = 3'($urandom_range(0, 7));
      acc = ($urandom_range(0, 2) == 0);
      len = acc ? $urandom_range(1, 6) : 1;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(8'($urandom), 8'($urandom),
             (k == 0) ? op : 3'($urandom_range(0, 7)),
             (k == 0) ? acc : 1'($urandom_range(0, 1)),
             k == len - 1);
      end
    end
    rand_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
